// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   - RegBus / RegAddrBus register-file widths, ZeroWord and WriteDisable.
//   - 8-bit aluop codes of the load/store instructions.
//   - mem_stage FSM state encoding (IDLE/WAIT/DONE/DRAIN).
//   - Helpers classifying aluop codes.
package mem_stage_pkg;

    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;

    localparam RegBus ZeroWord     = 32'h0000_0000;
    localparam logic  WriteDisable = 1'b0;

    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_load_op(op) || is_store_op(op);
    endfunction

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=00.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[0];
            EXE_LW_OP, EXE_SW_OP:             return (a != 2'b00);
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational byte-lane formatter for the MEM stage.
// Ports:
//   aluop_i  - load/store operation code
//   addr_i   - low two bits of the effective address
//   rt_i     - store source register
//   rdata_i  - word returned by the data bus
//   sel_o    - byte-lane enables for the bus
//   wdata_o  - store data replicated across the lanes
//   load_o   - selected lane, sign- or zero-extended to 32 bits
// BIG_ENDIAN=1 maps addr[1:0]=00 to bits [31:24]; 0 maps it to bits [7:0].
module mem_lane_fmt
    import mem_stage_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [1:0]  byte_lane;  // physical lane index, 0 = bits [7:0]
    logic        half_hi;    // 1 = halfword lives in bits [31:16]
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_lane = (BIG_ENDIAN != 0) ? ~addr_i : addr_i;
        half_hi   = (BIG_ENDIAN != 0) ? ~addr_i[1] : addr_i[1];

        case (byte_lane)
            2'd0:    byte_val = rdata_i[7:0];
            2'd1:    byte_val = rdata_i[15:8];
            2'd2:    byte_val = rdata_i[23:16];
            default: byte_val = rdata_i[31:24];
        endcase
        half_val = half_hi ? rdata_i[31:16] : rdata_i[15:0];

        sel_o   = 4'b0000;
        wdata_o = ZeroWord;
        load_o  = ZeroWord;

        case (aluop_i)
            EXE_LB_OP: begin
                sel_o  = 4'b0001 << byte_lane;
                load_o = {{24{byte_val[7]}}, byte_val};
            end
            EXE_LBU_OP: begin
                sel_o  = 4'b0001 << byte_lane;
                load_o = {24'h000000, byte_val};
            end
            EXE_LH_OP: begin
                sel_o  = half_hi ? 4'b1100 : 4'b0011;
                load_o = {{16{half_val[15]}}, half_val};
            end
            EXE_LHU_OP: begin
                sel_o  = half_hi ? 4'b1100 : 4'b0011;
                load_o = {16'h0000, half_val};
            end
            EXE_LW_OP: begin
                sel_o  = 4'b1111;
                load_o = rdata_i;
            end
            EXE_SB_OP: begin
                sel_o   = 4'b0001 << byte_lane;
                wdata_o = {4{rt_i[7:0]}};
            end
            EXE_SH_OP: begin
                sel_o   = half_hi ? 4'b1100 : 4'b0011;
                wdata_o = {2{rt_i[15:0]}};
            end
            EXE_SW_OP: begin
                sel_o   = 4'b1111;
                wdata_o = rt_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS core, between ex_mem and mem_wb.
// Non-memory instructions pass straight through. Loads/stores run a req/ack
// transaction on the data bus and hold the pipeline through stallreq_o.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush_i             - pipeline flush from ctrl
//   mem_*_i             - instruction bundle from ex_mem
//   wd_o..whilo_o       - write-back bundle latched by mem_wb
//   stallreq_o          - stall request to ctrl
//   dbg_state_o         - current FSM state (mem_state_e encoding)
//   dbus_*              - data bus; dbus_ack is a one-cycle completion strobe
//   excpt_misalign_o    - misaligned access flag (only with MEM_ALIGN_CHECK_EN)
// Bus handshake: dbus_req rises the cycle after a load/store is seen in IDLE
// and stays high with we/addr/sel/wdata stable until the cycle in which
// dbus_ack=1; that cycle completes the transfer and dbus_req drops on the
// following edge. dbus_ack while dbus_req=0 is ignored.
// Optional build macro: MEM_ALIGN_CHECK_EN adds excpt_misalign_o.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [7:0]        mem_aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_reg2_i,
    input  logic [4:0]        mem_wd_i,
    input  logic              mem_wreg_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [31:0]       mem_hi_i,
    input  logic [31:0]       mem_lo_i,
    input  logic              mem_whilo_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              whilo_o,
    output logic              stallreq_o,
    output logic [1:0]        dbg_state_o,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_sel,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_ack,
    input  logic [31:0]       dbus_rdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              excpt_misalign_o
`endif
);

    mem_state_e        state_q, state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [3:0]        fmt_sel;
    logic [31:0]       fmt_wdata;
    logic [31:0]       fmt_load;
    logic              misalign_w;
    logic              mem_op_w;
    logic              load_op_w;

    // The formatter serves both directions: at issue it uses the live rt and
    // address; in DONE the address is still held by ex_mem, so the same
    // instance extracts the lane from the captured read word.
    mem_lane_fmt #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_fmt (
        .aluop_i (mem_aluop_i),
        .addr_i  (mem_addr_i[1:0]),
        .rt_i    (mem_reg2_i),
        .rdata_i (rdata_q),
        .sel_o   (fmt_sel),
        .wdata_o (fmt_wdata),
        .load_o  (fmt_load)
    );

    assign mem_op_w  = is_mem_op(mem_aluop_i);
    assign load_op_w = is_load_op(mem_aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_w = is_misaligned(mem_aluop_i, mem_addr_i[1:0]);
`else
    assign misalign_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= ZeroWord;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= 4'b0000;
            wdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        wd_o       = mem_wd_i;
        wreg_o     = mem_wreg_i;
        wdata_o    = mem_wdata_i;
        hi_o       = mem_hi_i;
        lo_o       = mem_lo_i;
        whilo_o    = mem_whilo_i;
        stallreq_o = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        excpt_misalign_o = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    wreg_o  = WriteDisable;
                    whilo_o = WriteDisable;
                end else if (mem_op_w) begin
                    // mem_wb gets a bubble while the transfer is in flight.
                    wreg_o  = WriteDisable;
                    whilo_o = WriteDisable;
                    if (misalign_w) begin
`ifdef MEM_ALIGN_CHECK_EN
                        excpt_misalign_o = 1'b1;
`endif
                    end else begin
                        stallreq_o = 1'b1;
                        req_d      = 1'b1;
                        we_d       = is_store_op(mem_aluop_i);
                        addr_d     = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        sel_d      = fmt_sel;
                        wdata_d    = fmt_wdata;
                        state_d    = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                stallreq_o = 1'b1;
                wreg_o     = WriteDisable;
                whilo_o    = WriteDisable;
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    sel_d   = 4'b0000;
                    wdata_d = ZeroWord;
                    // A flush racing the ack drops the data and skips DONE.
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d = dbus_rdata;
                        state_d = ST_DONE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                whilo_o = WriteDisable;
                if (flush_i || !load_op_w) begin
                    wreg_o = WriteDisable;
                end else begin
                    wdata_o = fmt_load;
                end
                state_d = ST_IDLE;
            end

            ST_DRAIN: begin
                // The bus cannot abort a request; wait out the ack and drop it.
                stallreq_o = 1'b1;
                wreg_o     = WriteDisable;
                whilo_o    = WriteDisable;
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    sel_d   = 4'b0000;
                    wdata_d = ZeroWord;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            wd_o       = '0;
            wreg_o     = WriteDisable;
            wdata_o    = ZeroWord;
            hi_o       = ZeroWord;
            lo_o       = ZeroWord;
            whilo_o    = WriteDisable;
            stallreq_o = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            excpt_misalign_o = 1'b0;
`endif
        end
    end

    assign dbg_state_o = rst ? ST_IDLE : state_q;
    assign dbus_req    = rst ? 1'b0 : req_q;
    assign dbus_we     = rst ? 1'b0 : we_q;
    assign dbus_addr   = rst ? '0 : addr_q;
    assign dbus_sel    = rst ? 4'b0000 : sel_q;
    assign dbus_wdata  = rst ? ZeroWord : wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (default BIG_ENDIAN=1).
// Table of single-instruction vectors plus hand sequences for flush, reset
// and misalignment corners; write-back results go through an expected queue.
module tb_mem_stage;
    import mem_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        flush_i = 1'b0;
    logic [7:0]  mem_aluop_i = 8'h00;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_reg2_i = 32'h0;
    logic [4:0]  mem_wd_i = 5'd0;
    logic        mem_wreg_i = 1'b0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic [31:0] mem_hi_i = 32'h0;
    logic [31:0] mem_lo_i = 32'h0;
    logic        mem_whilo_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        stallreq_o;
    logic [1:0]  dbg_state_o;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
    logic        excpt_misalign_o;
`endif

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .mem_aluop_i (mem_aluop_i),
        .mem_addr_i  (mem_addr_i),
        .mem_reg2_i  (mem_reg2_i),
        .mem_wd_i    (mem_wd_i),
        .mem_wreg_i  (mem_wreg_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_hi_i    (mem_hi_i),
        .mem_lo_i    (mem_lo_i),
        .mem_whilo_i (mem_whilo_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .whilo_o     (whilo_o),
        .stallreq_o  (stallreq_o),
        .dbg_state_o (dbg_state_o),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_sel    (dbus_sel),
        .dbus_wdata  (dbus_wdata),
        .dbus_ack    (dbus_ack),
        .dbus_rdata  (dbus_rdata)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .excpt_misalign_o (excpt_misalign_o)
`endif
    );

    // ---------------- scoreboard ----------------
    // Entry: {is_alu, wd, wreg, whilo, wdata, hi, lo}
    localparam int EW = 104;
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          waits;      // extra WAIT cycles before ack
        logic        wreg;
        logic [31:0] alu_wdata;
        logic [3:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_bus_wdata;
        logic [31:0] exp_wdata;
        logic        exp_wreg;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [7:0] op, input logic [31:0] a,
                                input logic [31:0] rt, input logic [31:0] rd, input int w,
                                input logic wr, input logic [31:0] aw, input logic [3:0] sel,
                                input logic we, input logic [31:0] bwd, input logic [31:0] ewd,
                                input logic ewr);
        vec_t v;
        v.name = n; v.aluop = op; v.addr = a; v.rt = rt; v.rdata = rd; v.waits = w;
        v.wreg = wr; v.alu_wdata = aw; v.exp_sel = sel; v.exp_we = we;
        v.exp_bus_wdata = bwd; v.exp_wdata = ewd; v.exp_wreg = ewr;
        return v;
    endfunction

    function automatic logic tb_is_mem(input logic [7:0] op);
        return op inside {8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_nop();
        mem_aluop_i = 8'h00; mem_addr_i = 32'h0; mem_reg2_i = 32'h0; mem_wd_i = 5'd0;
        mem_wreg_i = 1'b0; mem_wdata_i = 32'h0; mem_hi_i = 32'h0; mem_lo_i = 32'h0;
        mem_whilo_i = 1'b0;
    endtask

    task automatic drive_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rt,
                            input logic wr);
        mem_aluop_i = op; mem_addr_i = a; mem_reg2_i = rt; mem_wd_i = 5'd9;
        mem_wreg_i = wr; mem_wdata_i = 32'hDEAD_BEEF; mem_hi_i = 32'h0; mem_lo_i = 32'h0;
        mem_whilo_i = 1'b0;
    endtask

    // Runs one instruction to completion, acting as the bus slave.
    task automatic run_op(input vec_t v, input int idx);
        int stall_n;
        int req_n;
        int cyc;
        bit done;
        bit wreg_leak;
        bit is_alu;
        logic [EW-1:0] e;
        logic e_alu; logic [4:0] e_wd; logic e_wreg; logic e_whilo;
        logic [31:0] e_wdata; logic [31:0] e_hi; logic [31:0] e_lo;

        is_alu = !tb_is_mem(v.aluop);
        @(posedge clk); #1;
        mem_aluop_i = v.aluop; mem_addr_i = v.addr; mem_reg2_i = v.rt;
        mem_wd_i = 5'((idx + 5) % 32); mem_wreg_i = v.wreg; mem_wdata_i = v.alu_wdata;
        mem_hi_i = 32'hA000_0000 | 32'(idx); mem_lo_i = 32'hB000_0000 | 32'(idx);
        mem_whilo_i = is_alu; flush_i = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h5A5A_5A5A;
        exp_q.push_back({is_alu, mem_wd_i, v.exp_wreg, is_alu, v.exp_wdata, mem_hi_i, mem_lo_i});

        stall_n = 0; req_n = 0; cyc = 0; done = 1'b0; wreg_leak = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (stallreq_o) begin
                stall_n++;
                if (wreg_o !== 1'b0) wreg_leak = 1'b1;
                if (dbus_req) begin
                    req_n++;
                    if (req_n == 1) begin
                        check({v.name, "_sel"}, 32'(dbus_sel), 32'(v.exp_sel));
                        check({v.name, "_we"}, 32'(dbus_we), 32'(v.exp_we));
                        check({v.name, "_addr"}, dbus_addr, v.addr & 32'hFFFF_FFFC);
                        if (v.exp_we) check({v.name, "_bus_wdata"}, dbus_wdata, v.exp_bus_wdata);
                    end
                    if (req_n == v.waits + 1) begin
                        dbus_ack = 1'b1;
                        dbus_rdata = v.rdata;
                    end
                end
            end else begin
                done = 1'b1;
                if (!is_alu) check({v.name, "_done_state"}, 32'(dbg_state_o), 32'(ST_DONE));
                e = exp_q.pop_front();
                {e_alu, e_wd, e_wreg, e_whilo, e_wdata, e_hi, e_lo} = e;
                check({v.name, "_wreg"}, 32'(wreg_o), 32'(e_wreg));
                check({v.name, "_whilo"}, 32'(whilo_o), 32'(e_whilo));
                if (e_wreg) begin
                    check({v.name, "_wdata"}, wdata_o, e_wdata);
                    check({v.name, "_wd"}, 32'(wd_o), 32'(e_wd));
                end
                if (e_alu) begin
                    check({v.name, "_hi"}, hi_o, e_hi);
                    check({v.name, "_lo"}, lo_o, e_lo);
                    check({v.name, "_busreq"}, 32'(dbus_req), 32'h0);
                end
            end
            if (!done) begin
                @(posedge clk); #1;
                dbus_ack = 1'b0;
                dbus_rdata = 32'h5A5A_5A5A;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d cycles required=completion", v.name, cyc);
            void'(exp_q.pop_front());
        end
        check({v.name, "_stall_cycles"}, 32'(stall_n), is_alu ? 32'd0 : 32'(v.waits + 2));
        check({v.name, "_req_cycles"}, 32'(req_n), is_alu ? 32'd0 : 32'(v.waits + 1));
        check({v.name, "_wreg_bubble"}, 32'(wreg_leak), 32'h0);
    endtask

    function automatic logic any_output_set();
        return |{wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o, dbg_state_o,
                 dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata};
    endfunction

    // ---------------- test ----------------
    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        bit ok;
        bit leak;
        vec_t rv;
        logic [31:0] ra;
        logic [31:0] rd;

        vecs[0]  = mk("alu_pass", 8'h21, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0000_1234,
                      4'b0000, 1'b0, 32'h0, 32'h0000_1234, 1'b1);
        vecs[1]  = mk("lb_103", EXE_LB_OP, 32'h103, 32'h0, 32'hAABB_CC80, 1, 1'b1, 32'hDEAD_0001,
                      4'b0001, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b1);
        vecs[2]  = mk("lhu_202", EXE_LHU_OP, 32'h202, 32'h0, 32'h1111_F00D, 0, 1'b1, 32'hDEAD_0002,
                      4'b0011, 1'b0, 32'h0, 32'h0000_F00D, 1'b1);
        vecs[3]  = mk("sb_301", EXE_SB_OP, 32'h301, 32'h0000_00A5, 32'h0, 0, 1'b1, 32'hDEAD_0003,
                      4'b0100, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0);
        vecs[4]  = mk("lb_100", EXE_LB_OP, 32'h100, 32'h0, 32'h7F00_0000, 2, 1'b1, 32'hDEAD_0004,
                      4'b1000, 1'b0, 32'h0, 32'h0000_007F, 1'b1);
        vecs[5]  = mk("lh_102", EXE_LH_OP, 32'h102, 32'h0, 32'h1234_8001, 0, 1'b1, 32'hDEAD_0005,
                      4'b0011, 1'b0, 32'h0, 32'hFFFF_8001, 1'b1);
`ifndef MEM_ALIGN_CHECK_EN
        vecs[6]  = mk("lh_101", EXE_LH_OP, 32'h101, 32'h0, 32'hABCD_0000, 1, 1'b1, 32'hDEAD_0006,
                      4'b1100, 1'b0, 32'h0, 32'hFFFF_ABCD, 1'b1);
`else
        vecs[6]  = mk("lh_100", EXE_LH_OP, 32'h100, 32'h0, 32'hABCD_0000, 1, 1'b1, 32'hDEAD_0006,
                      4'b1100, 1'b0, 32'h0, 32'hFFFF_ABCD, 1'b1);
`endif
        vecs[7]  = mk("lw_40c", EXE_LW_OP, 32'h40C, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_0007,
                      4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
        vecs[8]  = mk("sh_202", EXE_SH_OP, 32'h202, 32'h1234_BEEF, 32'h0, 1, 1'b1, 32'hDEAD_0008,
                      4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0, 1'b0);
        vecs[9]  = mk("sw_500", EXE_SW_OP, 32'h500, 32'h1234_5678, 32'h0, 0, 1'b1, 32'hDEAD_0009,
                      4'b1111, 1'b1, 32'h1234_5678, 32'h0, 1'b0);
        vecs[10] = mk("lbu_102", EXE_LBU_OP, 32'h102, 32'h0, 32'h0000_F000, 0, 1'b1, 32'hDEAD_000A,
                      4'b0010, 1'b0, 32'h0, 32'h0000_00F0, 1'b1);
        vecs[11] = mk("alu_nowr", 8'h25, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'hFFFF_0000,
                      4'b0000, 1'b0, 32'h0, 32'hFFFF_0000, 1'b0);
        vecs[12] = mk("lb_101", EXE_LB_OP, 32'h101, 32'h0, 32'h00C3_0000, 0, 1'b1, 32'hDEAD_000C,
                      4'b0100, 1'b0, 32'h0, 32'hFFFF_FFC3, 1'b1);

        // Reset: live inputs must not leak through while rst=1.
        drive_op(EXE_LW_OP, 32'h40, 32'h1, 1'b1);
        mem_hi_i = 32'h1; mem_lo_i = 32'h2; mem_whilo_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", 32'(any_output_set()), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_nop();
        @(negedge clk);
        check("reset_state_idle", 32'(dbg_state_o), 32'(ST_IDLE));
        check("reset_no_req", 32'(dbus_req), 32'h0);

        for (int i = 0; i < NV; i++) run_op(vecs[i], i);

        // Flush in WAIT, ack three cycles later: request held, data dropped.
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h600, 32'h0, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flushw_req_wait", 32'(dbus_req), 32'h1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        drive_nop();
        ok = 1'b1; leak = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) check("flushw_state_drain", 32'(dbg_state_o), 32'(ST_DRAIN));
            if (!dbus_req || !stallreq_o) ok = 1'b0;
            if (wreg_o) leak = 1'b1;
            if (k == 2) begin dbus_ack = 1'b1; dbus_rdata = 32'hBAD0_BAD0; end
            @(posedge clk); #1;
            dbus_ack = 1'b0;
        end
        @(negedge clk);
        check("flushw_req_held", 32'(ok), 32'h1);
        check("flushw_no_wb", 32'(leak | wreg_o), 32'h0);
        check("flushw_state_idle", 32'(dbg_state_o), 32'(ST_IDLE));
        check("flushw_stall_drop", 32'(stallreq_o), 32'h0);
        check("flushw_req_drop", 32'(dbus_req), 32'h0);

        // Flush and ack in the same WAIT cycle: straight back to IDLE.
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h604, 32'h0, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        dbus_ack = 1'b1; dbus_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dbus_ack = 1'b0; flush_i = 1'b0;
        drive_nop();
        @(negedge clk);
        check("flushack_state_idle", 32'(dbg_state_o), 32'(ST_IDLE));
        check("flushack_stall", 32'(stallreq_o), 32'h0);
        check("flushack_req", 32'(dbus_req), 32'h0);

        // Flush in DONE kills the write-back.
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h608, 32'h0, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        dbus_ack = 1'b1; dbus_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dbus_ack = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        check("flushdone_state", 32'(dbg_state_o), 32'(ST_DONE));
        check("flushdone_wreg", 32'(wreg_o), 32'h0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        drive_nop();
        @(negedge clk);
        check("flushdone_idle", 32'(dbg_state_o), 32'(ST_IDLE));

        // Flush in IDLE: ALU result bubbled, load not issued.
        @(posedge clk); #1;
        drive_op(8'h21, 32'h0, 32'h0, 1'b1);
        mem_whilo_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        check("flushidle_wreg", 32'(wreg_o), 32'h0);
        check("flushidle_whilo", 32'(whilo_o), 32'h0);
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h610, 32'h0, 1'b1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        drive_nop();
        @(negedge clk);
        check("flushidle_no_req", 32'(dbus_req), 32'h0);

        // Reset in the middle of WAIT; a late ack afterwards is ignored.
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h60C, 32'h0, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstwait_outputs_zero", 32'(any_output_set()), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstwait_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("rstwait_outputs_zero2", 32'(any_output_set()), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_nop();
        dbus_ack = 1'b1; dbus_rdata = 32'hFEED_FACE;
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("rstwait_late_ack_state", 32'(dbg_state_o), 32'(ST_IDLE));
        check("rstwait_late_ack_stall", 32'(stallreq_o), 32'h0);
        check("rstwait_late_ack_req", 32'(dbus_req), 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h402, 32'h0, 1'b1);
        @(negedge clk);
        check("misalign_flag", 32'(excpt_misalign_o), 32'h1);
        check("misalign_stall", 32'(stallreq_o), 32'h0);
        check("misalign_wreg", 32'(wreg_o), 32'h0);
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        check("misalign_flag_clear", 32'(excpt_misalign_o), 32'h0);
        check("misalign_no_req", 32'(dbus_req), 32'h0);
`endif

        // Random aligned word loads with random bus latency.
        for (int r = 0; r < 6; r++) begin
            ra = 32'($urandom_range(0, 1023)) << 2;
            rd = $urandom();
            rv = mk("rand_lw", EXE_LW_OP, ra, 32'h0, rd, int'($urandom_range(0, 3)), 1'b1,
                    32'hDEAD_0000, 4'b1111, 1'b0, 32'h0, rd, 1'b1);
            run_op(rv, 20 + r);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
